// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle control sequencer for the 8-bit ALU datapath.
// It steps through fetch, decode, execute, memory and writeback. Outputs are
// decoded from the registered state. Write strobes are held low while reset_n is low.
// Optional feature macro: ALU_CTRL_COND_BRANCH_EN
//   When defined, the flag register is present and branches test Cond.
//   When not defined, FlagsQ reads 0 and every branch is taken.
module alu_ctrl_fsm #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] Op,
    input  logic [2:0] Funct,
    input  logic       ImmSel,
    input  logic       L,
    input  logic [1:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       FlagWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic [2:0] ALUControl,
    output logic [3:0] FlagsQ,
    output logic       Halted,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd10
    } state_t;

    localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

    state_t     stateQ;
    logic [2:0] waitCnt;
    logic       waitDone;
    logic       branchTaken;
    logic [3:0] flagsReg;

    logic       pcWriteRaw;
    logic       irWriteRaw;
    logic       memWriteRaw;
    logic       regWriteRaw;
    logic       flagWriteRaw;

    assign waitDone = (waitCnt == WAIT_MAX);

    // State sequencing and the shared memory wait counter. The counter returns
    // to zero whenever it is not counting, so it is already clear on entry to
    // FETCH or MEMRD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ  <= FETCH;
            waitCnt <= 3'd0;
        end else begin
            if ((stateQ == FETCH || stateQ == MEMRD) && !waitDone) begin
                waitCnt <= waitCnt + 3'd1;
            end else begin
                waitCnt <= 3'd0;
            end
            case (stateQ)
                FETCH:  if (waitDone) stateQ <= DECODE;
                DECODE: begin
                    case (Op)
                        2'b00: begin
                            if (Funct <= 3'b101) stateQ <= ImmSel ? EXECI : EXECR;
                            else                 stateQ <= FETCH;
                        end
                        2'b01:   stateQ <= MEMADR;
                        2'b10:   stateQ <= BRANCH;
                        default: stateQ <= (Funct == 3'b111) ? HALT : FETCH;
                    endcase
                end
                EXECR, EXECI: stateQ <= ALUWB;
                MEMADR:       stateQ <= L ? MEMRD : MEMWR;
                MEMRD:        if (waitDone) stateQ <= MEMWB;
                HALT:         stateQ <= HALT;
                default:      stateQ <= FETCH;
            endcase
        end
    end

`ifdef ALU_CTRL_COND_BRANCH_EN
    // Flags are captured only by data-processing execute states, so a branch
    // sees the flags of the most recent arithmetic instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flagsReg <= 4'd0;
        end else if (flagWriteRaw) begin
            flagsReg <= ALUFlags;
        end
    end

    // Branch condition against the latched {CO,OVF,N,Z}.
    always_comb begin
        branchTaken = 1'b1;
        case (Cond)
            2'b01:   branchTaken = flagsReg[0];
            2'b10:   branchTaken = !flagsReg[0];
            2'b11:   branchTaken = flagsReg[1];
            default: branchTaken = 1'b1;
        endcase
    end
`else
    logic unusedInputs;
    assign unusedInputs = ^{ALUFlags, Cond};
    assign flagsReg     = 4'd0;
    assign branchTaken  = 1'b1;
`endif

    // Moore output decode. PCWrite in BRANCH is the only output that also
    // depends on the branch condition.
    always_comb begin
        pcWriteRaw   = 1'b0;
        irWriteRaw   = 1'b0;
        memWriteRaw  = 1'b0;
        regWriteRaw  = 1'b0;
        flagWriteRaw = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 1'b0;
        ALUControl   = 3'b000;
        case (stateQ)
            FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 1'b1;
                ResultSrc  = 2'b10;
                irWriteRaw = waitDone;
                pcWriteRaw = waitDone;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            EXECR, EXECI: begin
                ALUSrcB      = (stateQ == EXECI) ? 2'b01 : 2'b00;
                ALUOp        = 1'b1;
                ALUControl   = Funct;
                flagWriteRaw = 1'b1;
            end
            ALUWB: regWriteRaw = 1'b1;
            MEMADR: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                regWriteRaw = 1'b1;
                ResultSrc   = 2'b01;
            end
            MEMWR: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
            end
            BRANCH: pcWriteRaw = branchTaken;
            default: begin
            end
        endcase
    end

    assign PCWrite   = reset_n & pcWriteRaw;
    assign IRWrite   = reset_n & irWriteRaw;
    assign MemWrite  = reset_n & memWriteRaw;
    assign RegWrite  = reset_n & regWriteRaw;
    assign FlagWrite = reset_n & flagWriteRaw;
    assign FlagsQ    = flagsReg;
    assign Halted    = (stateQ == HALT);
    assign State     = stateQ;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed test of alu_ctrl_fsm with MEM_WAIT=0 and MEM_WAIT=2.
// Expectations follow ALU_CTRL_COND_BRANCH_EN when it is defined.
module tb_alu_ctrl_fsm;

    logic       clk;
    logic       reset_n;
    logic [1:0] Op;
    logic [2:0] Funct;
    logic       ImmSel;
    logic       L;
    logic [1:0] Cond;
    logic [3:0] ALUFlags;

    logic       pcWrite0, irWrite0, memWrite0, regWrite0, flagWrite0, adrSrc0;
    logic [1:0] resultSrc0, aluSrcB0;
    logic       aluSrcA0, aluOp0, halted0;
    logic [2:0] aluControl0;
    logic [3:0] flagsQ0, state0;

    logic       pcWrite2, irWrite2, memWrite2, regWrite2, flagWrite2, adrSrc2;
    logic [1:0] resultSrc2, aluSrcB2;
    logic       aluSrcA2, aluOp2, halted2;
    logic [2:0] aluControl2;
    logic [3:0] flagsQ2, state2;

    int errors = 0;
    int checks = 0;

`ifdef ALU_CTRL_COND_BRANCH_EN
    localparam logic [3:0] EXP_FLAGS_Z   = 4'b0001;
    localparam logic       EXP_NOT_TAKEN = 1'b0;
`else
    localparam logic [3:0] EXP_FLAGS_Z   = 4'b0000;
    localparam logic       EXP_NOT_TAKEN = 1'b1;
`endif

    alu_ctrl_fsm #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .ImmSel(ImmSel),
        .L(L), .Cond(Cond), .ALUFlags(ALUFlags),
        .PCWrite(pcWrite0), .IRWrite(irWrite0), .MemWrite(memWrite0),
        .RegWrite(regWrite0), .FlagWrite(flagWrite0), .AdrSrc(adrSrc0),
        .ResultSrc(resultSrc0), .ALUSrcA(aluSrcA0), .ALUSrcB(aluSrcB0),
        .ALUOp(aluOp0), .ALUControl(aluControl0), .FlagsQ(flagsQ0),
        .Halted(halted0), .State(state0)
    );

    alu_ctrl_fsm #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .ImmSel(ImmSel),
        .L(L), .Cond(Cond), .ALUFlags(ALUFlags),
        .PCWrite(pcWrite2), .IRWrite(irWrite2), .MemWrite(memWrite2),
        .RegWrite(regWrite2), .FlagWrite(flagWrite2), .AdrSrc(adrSrc2),
        .ResultSrc(resultSrc2), .ALUSrcA(aluSrcA2), .ALUSrcB(aluSrcB2),
        .ALUOp(aluOp2), .ALUControl(aluControl2), .FlagsQ(flagsQ2),
        .Halted(halted2), .State(state2)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] funct,
                                 input logic immSel, input logic l,
                                 input logic [1:0] cond, input logic [3:0] flags);
        Op       = op;
        Funct    = funct;
        ImmSel   = immSel;
        L        = l;
        Cond     = cond;
        ALUFlags = flags;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAndRelease();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    logic [3:0] loadStates [10];
    logic       loadIr     [10];
    logic       loadReg    [10];

    initial begin
        loadStates = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd0};
        loadIr     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        loadReg    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values and the register data-processing sequence 0,1,2,4,0.
        reset_n = 1'b0;
        applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 4'b0000);
        tick();
        checkOutput("rst_state",    8'(state0), 8'd0);
        checkOutput("rst_pcwrite",  8'(pcWrite0), 8'd0);
        checkOutput("rst_irwrite",  8'(irWrite0), 8'd0);
        checkOutput("rst_halted",   8'(halted0), 8'd0);
        checkOutput("rst_flagsq",   8'(flagsQ0), 8'd0);
        checkOutput("rst_alusrcb",  8'(aluSrcB0), 8'd2);
        checkOutput("rst_resultsrc",8'(resultSrc0), 8'd2);
        checkOutput("rst_alusrca",  8'(aluSrcA0), 8'd1);
        reset_n = 1'b1;
        #1;
        checkOutput("fetch_irwrite", 8'(irWrite0), 8'd1);
        checkOutput("fetch_aluop",   8'(aluOp0), 8'd1);
        tick();
        checkOutput("dp_decode",     8'(state0), 8'd1);
        checkOutput("dec_alusrcb",   8'(aluSrcB0), 8'd1);
        tick();
        checkOutput("dp_execr",      8'(state0), 8'd2);
        checkOutput("execr_flagwr",  8'(flagWrite0), 8'd1);
        checkOutput("execr_alusrca", 8'(aluSrcA0), 8'd0);
        checkOutput("execr_regwr",   8'(regWrite0), 8'd0);
        tick();
        checkOutput("dp_aluwb",      8'(state0), 8'd4);
        checkOutput("aluwb_regwr",   8'(regWrite0), 8'd1);
        checkOutput("aluwb_flagwr",  8'(flagWrite0), 8'd0);
        checkOutput("aluwb_ressrc",  8'(resultSrc0), 8'd0);
        tick();
        checkOutput("dp_back_fetch", 8'(state0), 8'd0);

        // Load with two wait cycles: nine cycles end to end.
        applyStimulus(2'b01, 3'b000, 1'b0, 1'b1, 2'b00, 4'b0000);
        resetAndRelease();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("ld_state_%0d", i), 8'(state2), 8'(loadStates[i]));
            checkOutput($sformatf("ld_irwr_%0d", i),  8'(irWrite2), 8'(loadIr[i]));
            checkOutput($sformatf("ld_regwr_%0d", i), 8'(regWrite2), 8'(loadReg[i]));
            if (i == 8) checkOutput("ld_ressrc", 8'(resultSrc2), 8'd1);
            if (i == 6) checkOutput("ld_adrsrc", 8'(adrSrc2), 8'd1);
            if (i < 9) tick();
        end

        // Immediate op sets Z, then EQ branch, then a NOP that must not touch flags.
        applyStimulus(2'b00, 3'b001, 1'b1, 1'b0, 2'b01, 4'b0001);
        resetAndRelease();
        tick();
        tick();
        checkOutput("dpi_state",    8'(state0), 8'd3);
        checkOutput("dpi_alusrcb",  8'(aluSrcB0), 8'd1);
        checkOutput("dpi_aluctl",   8'(aluControl0), 8'd1);
        checkOutput("dpi_flagwr",   8'(flagWrite0), 8'd1);
        tick();
        checkOutput("dpi_flagsq",   8'(flagsQ0), 8'(EXP_FLAGS_Z));
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 2'b01, 4'b0010);
        tick();
        tick();
        tick();
        checkOutput("beq_state",    8'(state0), 8'd9);
        checkOutput("beq_taken",    8'(pcWrite0), 8'd1);
        applyStimulus(2'b00, 3'b110, 1'b0, 1'b0, 2'b01, 4'b0010);
        tick();
        tick();
        checkOutput("nop_decode",   8'(state0), 8'd1);
        checkOutput("nop_flagwr",   8'(flagWrite0), 8'd0);
        checkOutput("nop_regwr",    8'(regWrite0), 8'd0);
        tick();
        checkOutput("nop_fetch",    8'(state0), 8'd0);
        checkOutput("nop_flagsq",   8'(flagsQ0), 8'(EXP_FLAGS_Z));

        // Immediate op clears Z, so the EQ branch is not taken when conditional.
        applyStimulus(2'b00, 3'b001, 1'b1, 1'b0, 2'b01, 4'b0000);
        tick();
        tick();
        tick();
        checkOutput("dpz_flagsq",   8'(flagsQ0), 8'd0);
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 2'b01, 4'b0000);
        tick();
        tick();
        tick();
        checkOutput("bnt_state",    8'(state0), 8'd9);
        checkOutput("bnt_pcwrite",  8'(pcWrite0), 8'(EXP_NOT_TAKEN));
        checkOutput("bnt_ressrc",   8'(resultSrc0), 8'd0);

        // HALT is sticky with all strobes low until reset.
        applyStimulus(2'b11, 3'b111, 1'b0, 1'b0, 2'b00, 4'b0000);
        resetAndRelease();
        tick();
        tick();
        checkOutput("halt_state",   8'(state0), 8'd10);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("halt_flag_%0d", i), 8'(halted0), 8'd1);
            checkOutput($sformatf("halt_strb_%0d", i),
                        8'({pcWrite0, irWrite0, memWrite0, regWrite0, flagWrite0}), 8'd0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        checkOutput("halt_rst_state",  8'(state0), 8'd0);
        checkOutput("halt_rst_halted", 8'(halted0), 8'd0);

        // Reset asserted in the middle of a store drops MemWrite at once.
        applyStimulus(2'b01, 3'b000, 1'b0, 1'b0, 2'b00, 4'b0000);
        resetAndRelease();
        tick();
        tick();
        tick();
        checkOutput("st_state",     8'(state0), 8'd8);
        checkOutput("st_memwr",     8'(memWrite0), 8'd1);
        checkOutput("st_adrsrc",    8'(adrSrc0), 8'd1);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("st_rst_memwr", 8'(memWrite0), 8'd0);
        checkOutput("st_rst_state", 8'(state0), 8'd0);
        checkOutput("st_rst_flagsq",8'(flagsQ0), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
